// File: rtl/flappy_game_sequencer.sv
// Game-flow controller for the Flappy Bird core: debounces the start and flap
// buttons, sequences IDLE/CLEAR/COUNTDOWN/PLAY/DYING/OVER, and issues the
// frame-locked update tick, tick-aligned flap pulses and the core clear pulse.
// It also keeps the high score across rounds.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   btn_start, btn_flap : raw asynchronous buttons (active-high)
//   frame_pulse         : one-cycle pulse per video frame
//   hit, bird_landed    : core collision / ground flags (levels)
//   score               : core score
//   core_clear          : one-cycle clear to the core
//   tick, flap_pulse    : game-update strobe and flap command issued with it
//   state               : current round state
//   high_score          : best score since reset
//   new_record          : last round set a new high score
module flappy_game_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TICK_FRAMES     = 1,
    parameter int unsigned COUNT_FRAMES    = 90,
    parameter int unsigned DIE_FRAMES      = 60,
    parameter int unsigned OVER_FRAMES     = 120
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_flap,
    input  logic       frame_pulse,
    input  logic       hit,
    input  logic       bird_landed,
    input  logic [7:0] score,
    output logic       core_clear,
    output logic       tick,
    output logic       flap_pulse,
    output logic [2:0] state,
    output logic [7:0] high_score,
    output logic       new_record
);

    localparam int unsigned DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TK_W       = $clog2(TICK_FRAMES + 1);
    localparam int unsigned FRAME_CD   = (COUNT_FRAMES > DIE_FRAMES) ? COUNT_FRAMES : DIE_FRAMES;
    localparam int unsigned FRAME_MAX  = (FRAME_CD > OVER_FRAMES) ? FRAME_CD : OVER_FRAMES;
    localparam int unsigned FR_W       = $clog2(FRAME_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_COUNTDOWN = 3'd2,
        S_PLAY      = 3'd3,
        S_DYING     = 3'd4,
        S_OVER      = 3'd5
    } state_t;

    // Button path, index 0 = start, 1 = flap
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_db;
    logic [1:0]      r_db_d;
    logic [1:0]      r_press;
    logic [DB_W-1:0] r_db_cnt [2];

    state_t          r_state;
    logic [FR_W-1:0] r_frame_cnt;
    logic [TK_W-1:0] r_tick_cnt;
    logic            r_flap_pending;

    logic            w_start_press;
    logic            w_flap_press;
    logic            w_ticking;
    logic            w_tick_fire;
    logic [FR_W-1:0] w_frame_inc;

    assign w_start_press = r_press[0];
    assign w_flap_press  = r_press[1];
    assign w_ticking     = (r_state == S_PLAY) || (r_state == S_DYING);
    assign w_tick_fire   = w_ticking && frame_pulse && (r_tick_cnt == TK_W'(TICK_FRAMES - 1));
    // Saturating frame count
    assign w_frame_inc   = (frame_pulse && (r_frame_cnt != FR_W'(FRAME_MAX)))
                         ? r_frame_cnt + FR_W'(1) : r_frame_cnt;
    assign state         = r_state;

    // Synchronize, debounce and edge-detect both buttons
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_d  <= '0;
            r_press <= '0;
            for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= {btn_flap, btn_start};
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            r_press <= r_db & ~r_db_d;
            for (int i = 0; i < 2; i++) begin
                // Count stays below DEBOUNCE_CYCLES, so it never wraps
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Round state machine with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_frame_cnt    <= '0;
            r_tick_cnt     <= '0;
            r_flap_pending <= 1'b0;
            core_clear     <= 1'b0;
            tick           <= 1'b0;
            flap_pulse     <= 1'b0;
            high_score     <= '0;
            new_record     <= 1'b0;
        end else begin
            core_clear  <= 1'b0;
            tick        <= w_tick_fire;
            // A hit in the same cycle suppresses the flap
            flap_pulse  <= w_tick_fire && r_flap_pending && !hit;
            r_frame_cnt <= w_frame_inc;

            // Tick phase runs continuously through PLAY and DYING
            if (!w_ticking)       r_tick_cnt <= '0;
            else if (w_tick_fire) r_tick_cnt <= '0;
            else if (frame_pulse) r_tick_cnt <= r_tick_cnt + TK_W'(1);

            case (r_state)
                S_IDLE: begin
                    if (w_start_press) begin
                        r_state        <= S_CLEAR;
                        core_clear     <= 1'b1;
                        new_record     <= 1'b0;
                        r_flap_pending <= 1'b0;
                        r_frame_cnt    <= '0;
                    end
                end
                S_CLEAR: begin
                    r_state     <= S_COUNTDOWN;
                    r_frame_cnt <= '0;
                end
                S_COUNTDOWN: begin
                    if (frame_pulse && (r_frame_cnt == FR_W'(COUNT_FRAMES - 1))) begin
                        r_state     <= S_PLAY;
                        r_frame_cnt <= '0;
                    end
                end
                S_PLAY: begin
                    if (hit) begin
                        r_state        <= S_DYING;
                        r_flap_pending <= 1'b0;
                        r_frame_cnt    <= '0;
                    end else if (w_tick_fire && r_flap_pending) begin
                        // Pending flap consumed; a coincident press waits for the next tick
                        r_flap_pending <= w_flap_press;
                    end else if (w_flap_press) begin
                        r_flap_pending <= 1'b1;
                    end
                end
                S_DYING: begin
                    r_flap_pending <= 1'b0;
                    if (bird_landed || (frame_pulse && (r_frame_cnt == FR_W'(DIE_FRAMES - 1)))) begin
                        r_state     <= S_OVER;
                        r_frame_cnt <= '0;
                        if (score > high_score) begin
                            high_score <= score;
                            new_record <= 1'b1;
                        end
                    end
                end
                S_OVER: begin
                    // Early presses are simply dropped, not queued
                    if (w_start_press && (r_frame_cnt >= FR_W'(OVER_FRAMES))) begin
                        r_state        <= S_CLEAR;
                        core_clear     <= 1'b1;
                        new_record     <= 1'b0;
                        r_flap_pending <= 1'b0;
                        r_frame_cnt    <= '0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_frame_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flappy_game_sequencer.sv
// Directed bench for flappy_game_sequencer: bounce filtering, countdown,
// tick/flap alignment, hit handling, death fall, high score, async reset.
module tb_flappy_game_sequencer;

    logic       clk;
    logic       reset_n;
    logic       btn_start;
    logic       btn_flap;
    logic       frame_pulse;
    logic       hit;
    logic       bird_landed;
    logic [7:0] score;
    logic       core_clear;
    logic       tick;
    logic       flap_pulse;
    logic [2:0] state;
    logic [7:0] high_score;
    logic       new_record;

    int n_vec  = 0;
    int n_miss = 0;

    // Frame generator / output monitor bookkeeping
    int         cyc        = 0;
    int         mis_align  = 0;
    int         orphan     = 0;
    int         bad_tick   = 0;
    int         flap_total = 0;
    int         cd_frames  = 0;
    logic [2:0] prev_state = 3'd0;

    flappy_game_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .TICK_FRAMES    (2),
        .COUNT_FRAMES   (3),
        .DIE_FRAMES     (5),
        .OVER_FRAMES    (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_start  (btn_start),
        .btn_flap   (btn_flap),
        .frame_pulse(frame_pulse),
        .hit        (hit),
        .bird_landed(bird_landed),
        .score      (score),
        .core_clear (core_clear),
        .tick       (tick),
        .flap_pulse (flap_pulse),
        .state      (state),
        .high_score (high_score),
        .new_record (new_record)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge just after a frame_pulse has been sampled
    task automatic sync_frame();
        @(posedge frame_pulse);
        @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, state, s);
    endtask

    // Sample outputs, then drive frame_pulse (one cycle every 20)
    always @(negedge clk) begin
        if (tick && !frame_pulse)                   mis_align++;
        if (flap_pulse && !tick)                    orphan++;
        if (tick && (state <= 3'd2))                bad_tick++;
        if (flap_pulse)                             flap_total++;
        if (prev_state == 3'd2 && frame_pulse)      cd_frames++;
        prev_state  = state;
        frame_pulse = (cyc % 20 == 19);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset_n     = 1'b0;
        btn_start   = 1'b0;
        btn_flap    = 1'b0;
        frame_pulse = 1'b0;
        hit         = 1'b0;
        bird_landed = 1'b0;
        score       = 8'd0;

        step(3);
        chk("rst_state", state, 0);
        chk("rst_core_clear", core_clear, 0);
        chk("rst_tick", tick, 0);
        chk("rst_flap", flap_pulse, 0);
        chk("rst_high", high_score, 0);
        chk("rst_record", new_record, 0);
        reset_n = 1'b1;
        step(2);

        // Bounce: 10 toggles every 2 cycles, then final rise held high
        for (int i = 0; i < 10; i++) begin
            btn_start = ~btn_start;
            step(2);
        end
        chk("bounce_no_press", state, 0);
        btn_start = 1'b1;
        step(7);
        chk("press_not_early", state, 0);
        step(1);
        chk("clear_state", state, 1);
        chk("clear_pulse", core_clear, 1);
        step(1);
        chk("countdown_state", state, 2);
        chk("clear_one_cycle", core_clear, 0);
        step(3);
        btn_start = 1'b0;

        // Countdown then first tick on the 2nd frame of PLAY
        wait_state(3'd3, 100, "countdown_to_play");
        n = 0;
        while (!tick && n < 100) begin
            step(1);
            n++;
        end
        chk("first_tick_latency", n, 40);

        // Flap pressed mid-interval rides on the next tick
        step(5);
        btn_flap = 1'b1;
        step(10);
        btn_flap = 1'b0;
        step(25);
        chk("tick2", tick, 1);
        chk("flap_with_tick", flap_pulse, 1);

        // Press lands in the frame cycle that issues a tick: held for the next one
        step(32);
        btn_flap = 1'b1;
        step(8);
        chk("tick3", tick, 1);
        chk("coincident_flap_held", flap_pulse, 0);
        btn_flap = 1'b0;
        step(40);
        chk("tick4", tick, 1);
        chk("held_flap_issued", flap_pulse, 1);

        // Hit and flap press in the same cycle
        step(2);
        btn_flap = 1'b1;
        step(7);
        chk("still_play", state, 3);
        hit = 1'b1;
        step(1);
        chk("hit_to_dying", state, 4);
        hit = 1'b0;
        step(2);
        btn_flap = 1'b0;
        score = 8'd7;
        step(28);
        chk("dying_after_2_frames", state, 4);
        chk("dying_tick", tick, 1);
        chk("dying_no_flap", flap_pulse, 0);
        bird_landed = 1'b1;
        step(1);
        chk("landed_to_over", state, 5);
        chk("high_7", high_score, 7);
        chk("record_set", new_record, 1);
        bird_landed = 1'b0;

        // Restart after the OVER hold
        repeat (4) sync_frame();
        btn_start = 1'b1;
        wait_state(3'd1, 30, "restart_r2");
        chk("r2_clear_pulse", core_clear, 1);
        step(1);
        chk("r2_countdown", state, 2);
        chk("r2_record_cleared", new_record, 0);
        chk("r2_high_kept", high_score, 7);
        btn_start = 1'b0;

        // Round 2: lower score, death fall ends on the 5th frame
        wait_state(3'd3, 100, "r2_play");
        score = 8'd5;
        sync_frame();
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        chk("r2_dying", state, 4);
        for (int i = 0; i < 4; i++) begin
            sync_frame();
            chk("r2_dying_hold", state, 4);
        end
        sync_frame();
        chk("die_timeout_over", state, 5);
        chk("r2_high_stays", high_score, 7);
        chk("r2_no_record", new_record, 0);

        // Start at frame 2 of OVER is dropped and not queued
        repeat (2) sync_frame();
        btn_start = 1'b1;
        step(10);
        btn_start = 1'b0;
        chk("early_start_ignored", state, 5);
        repeat (2) sync_frame();
        chk("early_start_not_queued", state, 5);
        btn_start = 1'b1;
        wait_state(3'd1, 30, "restart_r3");
        step(1);
        chk("r3_countdown", state, 2);
        btn_start = 1'b0;

        // Asynchronous reset in the middle of PLAY
        wait_state(3'd3, 100, "r3_play");
        step(5);
        reset_n = 1'b0;
        #1;
        chk("areset_state", state, 0);
        chk("areset_high", high_score, 0);
        chk("areset_tick", tick, 0);
        chk("areset_flap", flap_pulse, 0);
        chk("areset_clear", core_clear, 0);
        chk("areset_record", new_record, 0);
        step(3);
        reset_n = 1'b1;
        step(2);
        chk("post_reset_idle", state, 0);

        chk("tick_after_frame", mis_align, 0);
        chk("flap_only_with_tick", orphan, 0);
        chk("no_tick_outside_play", bad_tick, 0);
        chk("flap_total", flap_total, 2);
        chk("countdown_frames", cd_frames, 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/flappy_game_sequencer.md
# flappy_game_sequencer

Game-flow controller between the board buttons, the VGA frame timing and the Flappy Bird game core. Debounces the raw start and flap buttons and runs the round state machine: idle, countdown, play, death fall, game over. Issues the core's clear pulse, its frame-locked update tick and tick-aligned flap pulses, and keeps a high score across rounds.

## Interface
- DEBOUNCE_CYCLES, 1000000: consecutive stable clk cycles before a button level is accepted (10 ms at 100 MHz)
- TICK_FRAMES, 1: frames per game tick while ticking (1..15)
- COUNT_FRAMES, 90: countdown length in frames
- DIE_FRAMES, 60: maximum death-fall length in frames
- OVER_FRAMES, 120: minimum game-over hold before start is accepted
- clk  in  1  100 MHz system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- btn_start  in  1  raw start button, asynchronous, active-high
- btn_flap  in  1  raw flap button, asynchronous, active-high
- frame_pulse  in  1  one-cycle pulse per video frame, start of vertical blank, synchronous to clk
- hit  in  1  core collision flag, level
- bird_landed  in  1  core flag: bird at ground, level
- score  in  8  core score, unsigned
- core_clear  out  1  one-cycle synchronous clear to the core
- tick  out  1  one-cycle game-update strobe
- flap_pulse  out  1  one-cycle flap command, coincident with tick
- state  out  3  IDLE=0, CLEAR=1, COUNTDOWN=2, PLAY=3, DYING=4, OVER=5
- high_score  out  8  best score since reset
- new_record  out  1  high in OVER when the last round set a new high score

## Operation
- Button path, per button: 2-flop synchronizer, then a debouncer. The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count. A press is a one-cycle pulse on a 0->1 debounced edge. Holding a button gives one press.
- Frame counter: counts frame_pulse events. It clears on every state entry.
- IDLE: tick and flap blocked. A start press goes to CLEAR.
- CLEAR: lasts exactly one cycle. core_clear is asserted. Clears pending flap and new_record. Next state is COUNTDOWN.
- COUNTDOWN: no ticks. Goes to PLAY on the COUNT_FRAMES-th frame_pulse.
- PLAY: tick fires on every TICK_FRAMES-th frame_pulse. A flap press sets flap_pending. At the next tick, flap_pulse is issued and flap_pending is cleared. Goes to DYING when hit is high.
- DYING: ticks continue. Flap presses are ignored and flap_pending is cleared. Goes to OVER when bird_landed is high or on the DIE_FRAMES-th frame_pulse, whichever comes first.
- OVER: no ticks. On entry, if score > high_score (unsigned), high_score <= score and new_record <= 1. A start press is accepted only after OVER_FRAMES frame_pulses; it then goes to CLEAR. Earlier presses are discarded and not queued.
- Simultaneous events:
  - hit wins over flap in the same cycle; the flap is discarded.
  - In IDLE or OVER, start and flap pressed together act as start only.
  - A flap press in the same cycle as a tick with no pending flap is held for the next tick.
- Counter widths hold the parameter maximum. Counters saturate; they never wrap.

## Timing
- Reset values: state=IDLE, core_clear=0, tick=0, flap_pulse=0, high_score=0, new_record=0, flap_pending=0, debounced levels=0, all counters 0. reset_n mid-round aborts immediately to these values.
- All outputs are registered.
- tick is asserted in the cycle after the qualifying frame_pulse.
- Button-to-press latency: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- State transitions take effect the cycle after the causing input. The state output is the current register value.
- core_clear precedes the first COUNTDOWN cycle by one cycle.
- hit sampled in the cycle of a tick: the state becomes DYING next cycle. That tick has already been issued; no flap_pulse accompanies any later tick.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, TICK_FRAMES=2, COUNT_FRAMES=3, DIE_FRAMES=5, OVER_FRAMES=4, frame_pulse every 20 cycles.

- Bounce: btn_start toggles every 2 cycles for 20 cycles, then holds high. Required: exactly one press, 7 cycles after the final rise. IDLE->CLEAR for one cycle with core_clear=1, then COUNTDOWN.
- Countdown and ticks: after start, no tick for 3 frames. In PLAY, a tick one cycle after every 2nd frame_pulse.
- Flap alignment: flap press mid-interval. Required: flap_pulse=1 exactly with the next tick, only once. A second press in the tick cycle appears at the following tick.
- Hit and flap in the same cycle in PLAY. Required: DYING next cycle, no flap_pulse ever. bird_landed=1 after 2 frames gives OVER; without bird_landed, OVER on the 5th frame.
- High score: score=7 at OVER entry gives high_score=7, new_record=1. Next round score=5: high_score stays 7, new_record=0. Start pressed at frame 2 of OVER is ignored; accepted after frame 4.
- reset_n pulsed low in PLAY with high_score=7. Required: all outputs go to reset values asynchronously, high_score=0, state=IDLE.
